vec_normalizer_seq: RTL
=======================

# vec_normalizer_seq

Parametrised, time-multiplexed successor to the four-channel pipelined normalizer. It accepts one vector of NUM_CH unsigned channels per transaction and returns each channel divided by the vector's Euclidean length, x_i / floor(sqrt(sum x_j²)), as an unsigned fixed-point value. A single squarer/accumulator, a bit-serial square root and a bit-serial divider are shared under one FSM, trading throughput for area. Input and output use valid/ready handshakes, so the block drops into any streaming datapath in the design.

## Interface
- DATAWIDTH, 8: width of each unsigned input channel.
- NUM_CH, 4: channel count, ≥1.
- FRAC_BITS, 8: fractional bits of each output quotient.
- Derived SUMW = 2*DATAWIDTH + $clog2(NUM_CH): accumulator width.
- Derived RW = (SUMW+1)/2: root width.
- Derived DQ = DATAWIDTH + FRAC_BITS: dividend width and divide iterations per channel.
- Derived OW = FRAC_BITS + 1: output width per channel. The quotient is always ≤ 2^FRAC_BITS.
- clk  input  1: single clock, rising edge.
- rst  input  1: asynchronous, active-low reset.
- i_valid  input  1: input vector valid.
- i_ready  output  1: block accepts an input; equals (state == IDLE).
- i_data  input  NUM_CH*DATAWIDTH: channel k is in bits [k*DATAWIDTH +: DATAWIDTH].
- o_valid  output  1: result valid.
- o_ready  input  1: downstream accepts the result.
- o_data  output  NUM_CH*OW: channel k is in bits [k*OW +: OW].
- o_div0  output  1: set when the vector norm is zero. It is valid together with o_valid.

## Operation
- The FSM has five states: IDLE, SQ, SQRT, DIV, DONE.
- IDLE:
  - i_ready = 1.
  - When i_valid && i_ready, capture i_data into an internal vector register, clear the accumulator, and go to SQ.
- SQ:
  - One channel per cycle, k = 0 .. NUM_CH-1: acc += x_k * x_k.
  - After NUM_CH cycles, go to SQRT.
  - acc cannot overflow at SUMW bits.
- SQRT:
  - Restoring bit-serial integer square root of acc, producing one root bit per cycle, MSB first, for RW cycles.
  - Result: root = floor(sqrt(acc)). The remainder is discarded.
  - If root == 0, write o_data = 0 and o_div0 = 1, then go to DONE, skipping DIV.
  - Otherwise go to DIV.
- DIV:
  - For each channel k in order 0 .. NUM_CH-1, run a restoring division of (x_k << FRAC_BITS) by root.
  - Each division takes DQ cycles and produces one quotient bit per cycle, MSB first.
  - Quotient = floor(x_k * 2^FRAC_BITS / root). The low OW bits go to o_data channel k, and o_div0 = 0.
  - The upper DQ-OW quotient bits are guaranteed zero, because x_k ≤ root.
  - After the last channel, go to DONE.
- DONE:
  - o_valid = 1. o_data and o_div0 are held stable.
  - On o_valid && o_ready, go to IDLE.
- i_valid is ignored outside IDLE; there is no input buffering.
- The output registers change only on the SQRT→DONE transition or at the end of DIV.

## Timing
- Reset values (while rst is low):
  - State IDLE, so i_ready = 1, but inputs are ignored while rst = 0.
  - o_valid = 0, o_data = 0, o_div0 = 0, all internal registers 0.
- Latency, counted in rising edges after the acceptance edge until o_valid is high:
  - Nonzero norm: L = NUM_CH + RW + NUM_CH*DQ. With the defaults, 4 + 9 + 64 = 77.
  - Zero norm: L0 = NUM_CH + RW. With the defaults, 13.
- Throughput: one vector per L+2 cycles at best, since DONE lasts at least one cycle and IDLE lasts one.
- There is no path from o_ready to i_ready in the same cycle. If DONE completes at edge T, the earliest next acceptance is edge T+1.
- Backpressure: o_valid may stay high indefinitely. o_data must not change while o_valid && !o_ready.
- Reset mid-operation: asserting rst in any state aborts the transaction immediately. No partial result is ever presented, and the first edge after deassertion behaves as IDLE.
- Boundaries:
  - All inputs at maximum: no overflow; each quotient equals 2^FRAC_BITS/sqrt(NUM_CH), truncated.
  - Exactly one nonzero channel: that quotient = 2^FRAC_BITS, the maximum OW-bit value.

## Test plan
All scenarios use the defaults DATAWIDTH=8, NUM_CH=4, FRAC_BITS=8.
- Accept (3,4,0,0) -> root 5; o_data = (153, 204, 0, 0); o_div0 = 0; o_valid exactly 77 edges after acceptance.
- Accept (255,255,255,255) -> sum 260100, root 510; every channel = 128; no overflow.
- Accept (0,0,0,0) -> o_div0 = 1, o_data = 0, o_valid 13 edges after acceptance.
- Accept (0,0,200,0) -> o_data = (0, 0, 256, 0), the full-scale quotient.
- Result pending with o_ready low for 10 cycles, i_valid held high -> o_valid and o_data stable, i_ready = 0, no vector accepted; one cycle after the o_ready handshake, the next vector is accepted.
- Drive rst low at edge 40 of a DIV transaction -> o_valid = 0 and o_data = 0 immediately; after release, accept (1,1,1,1) -> root 2; every channel = 128 after 77 edges.

Source files
------------

// File: rtl/vec_normalizer_seq.sv
// rtl/vec_normalizer_seq.sv - time-multiplexed vector normalizer x_k / floor(sqrt(sum x^2))
module vec_normalizer_seq #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_CH    = 4,
    parameter int FRAC_BITS = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_valid,
    output logic                              i_ready,
    input  logic [NUM_CH*DATAWIDTH-1:0]       i_data,
    output logic                              o_valid,
    input  logic                              o_ready,
    output logic [NUM_CH*(FRAC_BITS+1)-1:0]   o_data,
    output logic                              o_div0
);
    localparam int SUMW = 2*DATAWIDTH + $clog2(NUM_CH);
    localparam int RW   = (SUMW + 1) / 2;
    localparam int AW   = 2*RW;
    localparam int DQ   = DATAWIDTH + FRAC_BITS;
    localparam int OW   = FRAC_BITS + 1;
    localparam int MAXB = (DQ > RW) ? DQ : RW;
    localparam int BW   = $clog2(MAXB);
    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CHW-1:0] CH_LAST = CHW'(NUM_CH - 1);
    localparam logic [CHW-1:0] CH_ONE  = CHW'(1);
    localparam logic [BW-1:0]  RW_LAST = BW'(RW - 1);
    localparam logic [BW-1:0]  DQ_LAST = BW'(DQ - 1);
    localparam logic [BW-1:0]  BIT_ONE = BW'(1);

    typedef enum logic [2:0] {S_IDLE, S_SQ, S_SQRT, S_DIV, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [DATAWIDTH-1:0]   r_x [NUM_CH];
    logic [AW-1:0]          r_acc;
    logic [RW-1:0]          r_root;
    logic [RW-1:0]          r_rem;
    logic [RW-1:0]          r_drem;
    logic [OW-2:0]          r_quo;
    logic [OW-1:0]          r_qv [NUM_CH];
    logic [NUM_CH*OW-1:0]   r_odata;
    logic                   r_div0;
    logic [CHW-1:0]         r_ch;
    logic [BW-1:0]          r_bit;

    logic [DATAWIDTH-1:0]   w_xk;
    logic [2*DATAWIDTH-1:0] w_sq;
    logic [RW+1:0]          w_rem_sh;
    logic [RW+1:0]          w_trial;
    logic                   w_rbit;
    logic [RW-1:0]          w_rem_nx;
    logic [RW-1:0]          w_root_nx;
    logic                   w_dbit;
    logic [RW:0]            w_drem_sh;
    logic                   w_qbit;
    logic [RW-1:0]          w_drem_nx;
    logic [OW-1:0]          w_quo_nx;
    logic                   w_ch_last;
    logic                   w_sqrt_last;
    logic                   w_bit_last;
    logic                   w_root_zero;

    assign w_xk = r_x[r_ch];
    assign w_sq = w_xk * w_xk;

    // Restoring square root: bring down two radicand bits, try (root<<2)|1
    assign w_rem_sh  = {r_rem, r_acc[AW-1 -: 2]};
    assign w_trial   = {r_root, 2'b01};
    assign w_rbit    = (w_rem_sh >= w_trial);
    assign w_rem_nx  = w_rbit ? RW'(w_rem_sh - w_trial) : w_rem_sh[RW-1:0];
    assign w_root_nx = {r_root[RW-2:0], w_rbit};

    // The channel register is shifted left during its division, so its MSB
    // streams the dividend bits and the zero fill supplies the fraction bits
    assign w_dbit    = w_xk[DATAWIDTH-1];
    assign w_drem_sh = {r_drem, w_dbit};
    assign w_qbit    = (w_drem_sh >= {1'b0, r_root});
    assign w_drem_nx = w_qbit ? RW'(w_drem_sh - {1'b0, r_root}) : w_drem_sh[RW-1:0];
    assign w_quo_nx  = {r_quo, w_qbit};

    assign w_ch_last   = (r_ch == CH_LAST);
    assign w_sqrt_last = (r_bit == RW_LAST);
    assign w_bit_last  = (r_bit == DQ_LAST);
    assign w_root_zero = (w_root_nx == '0);

    assign i_ready = (r_state == S_IDLE);
    assign o_valid = (r_state == S_DONE);
    assign o_data  = r_odata;
    assign o_div0  = r_div0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_valid) w_next = S_SQ;
            S_SQ:   if (w_ch_last) w_next = S_SQRT;
            S_SQRT: if (w_sqrt_last) w_next = w_root_zero ? S_DONE : S_DIV;
            S_DIV:  if (w_bit_last && w_ch_last) w_next = S_DONE;
            S_DONE: if (o_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_x[k]  <= '0;
                r_qv[k] <= '0;
            end
            r_acc   <= '0;
            r_root  <= '0;
            r_rem   <= '0;
            r_drem  <= '0;
            r_quo   <= '0;
            r_odata <= '0;
            r_div0  <= 1'b0;
            r_ch    <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        for (int k = 0; k < NUM_CH; k++)
                            r_x[k] <= i_data[k*DATAWIDTH +: DATAWIDTH];
                        r_acc <= '0;
                        r_ch  <= '0;
                    end
                end
                S_SQ: begin
                    r_acc <= r_acc + AW'(w_sq);
                    if (w_ch_last) begin
                        r_ch   <= '0;
                        r_bit  <= '0;
                        r_rem  <= '0;
                        r_root <= '0;
                    end else begin
                        r_ch <= r_ch + CH_ONE;
                    end
                end
                S_SQRT: begin
                    r_acc  <= r_acc << 2;
                    r_rem  <= w_rem_nx;
                    r_root <= w_root_nx;
                    r_bit  <= r_bit + BIT_ONE;
                    if (w_sqrt_last) begin
                        r_bit  <= '0;
                        r_ch   <= '0;
                        r_drem <= '0;
                        r_quo  <= '0;
                        if (w_root_zero) begin
                            r_odata <= '0;
                            r_div0  <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    r_x[r_ch] <= w_xk << 1;
                    r_drem    <= w_drem_nx;
                    r_quo     <= w_quo_nx[OW-2:0];
                    r_bit     <= r_bit + BIT_ONE;
                    if (w_bit_last) begin
                        r_bit      <= '0;
                        r_drem     <= '0;
                        r_quo      <= '0;
                        r_qv[r_ch] <= w_quo_nx;
                        r_ch       <= r_ch + CH_ONE;
                        if (w_ch_last) begin
                            for (int k = 0; k < NUM_CH; k++)
                                r_odata[k*OW +: OW] <= (CHW'(k) == r_ch) ? w_quo_nx : r_qv[k];
                            r_div0 <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
